scan_code_history: RTL and testbench
====================================

# scan_code_history

Parametrised PS/2 scan-code history and display scanner. Consumes decoded bytes from the PS/2 receiver (`valid_code`/`scan_code_in`) and tracks make, break and extended (E0) prefixes. It keeps the last NUM_DIGITS completed key codes in a history buffer and time-multiplexes them onto an active-low seven-segment digit-enable bus for the downstream hex-to-segment decoder.

## Interface
- `NUM_DIGITS`, 4: history depth and number of display digits; legal values 2..8.
- `REFRESH_DIV`, 131072: clocks per digit slot; minimum 2.
- `CAPTURE_MODE`, 1: 0 records make codes, 1 records break (release) codes.
- `clk` in 1: single system clock.
- `rst` in 1: synchronous, active-high reset.
- `valid_code` in 1: one-cycle strobe; `scan_code_in` is valid this cycle.
- `scan_code_in` in 8: received PS/2 byte.
- `clear` in 1: synchronous flush of history and decoder FSM.
- `code_to_display` out 8: code for the currently enabled digit; 8'h00 if that entry is empty.
- `ext_to_display` out 1: the displayed code carried an E0 prefix.
- `digit_valid` out 1: the displayed entry holds a captured code.
- `seg_en` out NUM_DIGITS: active-low one-cold digit enable.
- `code_pushed` out 1: one-cycle pulse when an entry is written.
- `fill_level` out clog2(NUM_DIGITS+1): number of valid entries, saturating at NUM_DIGITS.

## Operation
- Decoder FSM has four states: IDLE, BRK, EXT, EXT_BRK. It advances only on `valid_code`.
  - IDLE: F0 goes to BRK. E0 goes to EXT. Any other byte is pushed with ext=0 when CAPTURE_MODE=0; state stays IDLE.
  - BRK: F0 stays in BRK. E0 goes to EXT (resync). Any other byte is pushed with ext=0 when CAPTURE_MODE=1, then IDLE.
  - EXT: F0 goes to EXT_BRK. E0 stays in EXT. Any other byte is pushed with ext=1 when CAPTURE_MODE=0, then IDLE.
  - EXT_BRK: F0 and E0 stay in EXT_BRK. Any other byte is pushed with ext=1 when CAPTURE_MODE=1, then IDLE.
- Push behaviour:
  - Entries shift up: entry[i] <= entry[i-1]; the new code goes to entry[0]. The oldest entry is discarded when full.
  - Each entry is {valid, ext, code[7:0]}.
  - `fill_level` increments per push and saturates at NUM_DIGITS.
- Priority: `rst` > `clear` > `valid_code`.
  - `clear` zeroes all entries and `fill_level` and forces IDLE; a `valid_code` in the same cycle is dropped.
  - `clear` does not disturb the refresh counter or digit index.
- Scanner:
  - The refresh counter runs 0..REFRESH_DIV-1.
  - On wrap, `digit_idx` advances modulo NUM_DIGITS; NUM_DIGITS-1 wraps to 0.
  - Digit i displays entry[i]; digit 0 (newest) is `seg_en[0]`.
- Reset values:
  - FSM in IDLE; all entries 0; counter 0; `digit_idx` 0.
  - `seg_en` = all ones except bit 0 = 0.
  - `code_to_display` 0, `ext_to_display` 0, `digit_valid` 0, `code_pushed` 0, `fill_level` 0.

## Timing
- All outputs are registered.
- `code_pushed` is high in the cycle after the `valid_code` that completes a code.
- The entry is updated at the same edge.
- Display outputs sample the buffer and `digit_idx` every cycle, so one cycle of latency.
  - A push is visible on the enabled digit one cycle after `code_pushed`.
- Push and digit advance in the same cycle: both take effect. The display shows the post-push buffer for the new index one cycle later.
- `seg_en`, `code_to_display`, `ext_to_display` and `digit_valid` change on the same edge, so there are no mixed-digit cycles.
- Back-to-back `valid_code` on consecutive cycles must be handled; each byte advances the FSM once.

## Structure
- Shared package `kbd_pkg`:
  - `BREAK_CODE` = 8'hF0, `EXT_CODE` = 8'hE0.
  - Decoder state typedef (IDLE/BRK/EXT/EXT_BRK).
  - History entry typedef.
- Sub-module `digit_scanner`, parameters NUM_DIGITS and REFRESH_DIV:
  - Contains the refresh counter, `digit_idx` and the one-cold `seg_en` generation.
  - Outputs `digit_idx` to the top level.
- Top level holds the decoder FSM, history shift register and output mux/registers.

## Test plan
All scenarios use NUM_DIGITS=4 and REFRESH_DIV=4.
- Break mode: send 1C, F0, 1C. Expect one `code_pushed`; entry0 = 1C; `fill_level` = 1; when `seg_en` = 1110, `code_to_display` = 1C and `digit_valid` = 1.
- Extended: send E0, F0, 75. Expect entry0 = {1,1,75}; `ext_to_display` = 1 on digit 0. Send E0, 75 (make): no push.
- Overflow: release 1C, 32, 21, 23, 24. Expect entries 24, 23, 21, 32 (1C lost); `fill_level` stays 4.
- Scan: with 4 valid entries, `seg_en` cycles 1110→1101→1011→0111→1110, holding each for 4 clocks; `code_to_display` tracks the matching entry.
- Mode 0 plus clear: with CAPTURE_MODE=0, send 1C, F0, 1C. Expect exactly one push (the make). Then assert `clear` together with `valid_code`=32: buffer empty, `fill_level` 0, no push.
- Reset mid-sequence: send F0, assert `rst`, then send 1C. Expect no push; FSM treats 1C as a fresh byte in IDLE.

Source files
------------

// File: rtl/kbd_pkg.sv
// kbd_pkg
//   Shared constants and types for the PS/2 scan-code history block:
//   prefix byte values, decoder state encoding and the history entry format.
package kbd_pkg;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_t;

  typedef struct packed {
    logic       valid;
    logic       ext;
    logic [7:0] code;
  } hist_entry_t;

endpackage

// File: rtl/digit_scanner.sv
// digit_scanner
//   Refresh timer and digit selector for a time-multiplexed display.
//   Each digit slot lasts REFRESH_DIV clocks; digit_idx then advances modulo
//   NUM_DIGITS. seg_en is the active-low one-cold enable for the digit
//   selected by digit_idx, registered so it lines up with display data that
//   the parent registers from the same digit_idx.
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   digit_idx  out  index of the digit currently being selected
//   seg_en     out  active-low one-cold digit enable (lags digit_idx by 1)
module digit_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 131072,
  localparam int IDX_W = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1,
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [IDX_W-1:0]      digit_idx,
  output logic [NUM_DIGITS-1:0] seg_en
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] refresh_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
      seg_en      <= ~NUM_DIGITS'(1);
    end else begin
      if (refresh_cnt == CNT_LAST) begin
        refresh_cnt <= '0;
        digit_idx   <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      // Registered from the current index so it changes on the same edge as
      // the display data sampled from that index.
      seg_en <= ~(NUM_DIGITS'(1) << digit_idx);
    end
  end

endmodule

// File: rtl/scan_code_history.sv
// scan_code_history
//   PS/2 scan-code history and display scanner. Decodes make / break (F0) /
//   extended (E0) sequences from received bytes, pushes completed codes into
//   a NUM_DIGITS-deep history (newest in entry 0) and multiplexes the history
//   onto the display one digit at a time.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   ST_IDLE    | no prefix pending
//   ST_BRK     | F0 seen, next plain byte is a release
//   ST_EXT     | E0 seen, next plain byte is an extended make
//   ST_EXT_BRK | E0 F0 seen, next plain byte is an extended release
//
// Ports
//   clk              in   system clock
//   rst              in   synchronous active-high reset
//   valid_code       in   strobe, scan_code_in valid this cycle
//   scan_code_in     in   received PS/2 byte
//   clear            in   synchronous flush of history and decoder
//   code_to_display  out  code of the enabled digit (00 when empty)
//   ext_to_display   out  enabled digit's code had an E0 prefix
//   digit_valid      out  enabled digit holds a captured code
//   seg_en           out  active-low one-cold digit enable
//   code_pushed      out  one-cycle pulse when an entry is written
//   fill_level       out  valid entries, saturating at NUM_DIGITS
module scan_code_history
  import kbd_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 131072,
  parameter int CAPTURE_MODE = 1,
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int FILL_W = $clog2(NUM_DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_code,
  input  logic [7:0]            scan_code_in,
  input  logic                  clear,
  output logic [7:0]            code_to_display,
  output logic                  ext_to_display,
  output logic                  digit_valid,
  output logic [NUM_DIGITS-1:0] seg_en,
  output logic                  code_pushed,
  output logic [FILL_W-1:0]     fill_level
);

  localparam logic CAP_BREAK = (CAPTURE_MODE != 0);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(NUM_DIGITS);

  dec_state_t  state, state_nxt;
  logic        push, push_ext;
  hist_entry_t hist [NUM_DIGITS];
  logic [IDX_W-1:0] digit_idx;

  digit_scanner #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_scanner (
    .clk       (clk),
    .rst       (rst),
    .digit_idx (digit_idx),
    .seg_en    (seg_en)
  );

  // Prefix bytes never complete a code; a stray E0 after F0 resyncs to EXT,
  // repeated prefixes are absorbed.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_ext  = 1'b0;
    if (valid_code) begin
      unique case (state)
        ST_IDLE: begin
          if (scan_code_in == BREAK_CODE)    state_nxt = ST_BRK;
          else if (scan_code_in == EXT_CODE) state_nxt = ST_EXT;
          else                               push      = !CAP_BREAK;
        end
        ST_BRK: begin
          if (scan_code_in == BREAK_CODE)    state_nxt = ST_BRK;
          else if (scan_code_in == EXT_CODE) state_nxt = ST_EXT;
          else begin
            push      = CAP_BREAK;
            state_nxt = ST_IDLE;
          end
        end
        ST_EXT: begin
          if (scan_code_in == BREAK_CODE)    state_nxt = ST_EXT_BRK;
          else if (scan_code_in == EXT_CODE) state_nxt = ST_EXT;
          else begin
            push      = !CAP_BREAK;
            push_ext  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          if (scan_code_in == BREAK_CODE || scan_code_in == EXT_CODE) begin
            state_nxt = ST_EXT_BRK;
          end else begin
            push      = CAP_BREAK;
            push_ext  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      fill_level      <= '0;
      code_pushed     <= 1'b0;
      code_to_display <= 8'h00;
      ext_to_display  <= 1'b0;
      digit_valid     <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) hist[i] <= '0;
    end else begin
      // Display samples the pre-edge buffer; empty entries are all-zero so
      // the code reads 00 without extra muxing.
      code_to_display <= hist[digit_idx].code;
      ext_to_display  <= hist[digit_idx].ext;
      digit_valid     <= hist[digit_idx].valid;

      if (clear) begin
        state       <= ST_IDLE;
        fill_level  <= '0;
        code_pushed <= 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) hist[i] <= '0;
      end else begin
        state       <= state_nxt;
        code_pushed <= push;
        if (push) begin
          for (int i = NUM_DIGITS - 1; i > 0; i--) hist[i] <= hist[i-1];
          hist[0] <= '{valid: 1'b1, ext: push_ext, code: scan_code_in};
          if (fill_level != FILL_MAX) fill_level <= fill_level + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_scan_code_history.sv
// tb_scan_code_history
//   Directed bench. Two instances share all inputs: dut_b records releases
//   (CAPTURE_MODE=1), dut_m records makes (CAPTURE_MODE=0). Both use
//   NUM_DIGITS=4, REFRESH_DIV=4 so their scanners run in lockstep.
module tb_scan_code_history;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_code;
  logic [7:0] scan_code_in;
  logic       clear;

  logic [7:0] b_code, m_code;
  logic       b_ext, m_ext, b_dv, m_dv, b_push, m_push;
  logic [3:0] b_seg, m_seg;
  logic [2:0] b_fill, m_fill;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  scan_code_history #(.NUM_DIGITS(4), .REFRESH_DIV(4), .CAPTURE_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .valid_code(valid_code), .scan_code_in(scan_code_in),
    .clear(clear), .code_to_display(b_code), .ext_to_display(b_ext),
    .digit_valid(b_dv), .seg_en(b_seg), .code_pushed(b_push), .fill_level(b_fill)
  );

  scan_code_history #(.NUM_DIGITS(4), .REFRESH_DIV(4), .CAPTURE_MODE(0)) dut_m (
    .clk(clk), .rst(rst), .valid_code(valid_code), .scan_code_in(scan_code_in),
    .clear(clear), .code_to_display(m_code), .ext_to_display(m_ext),
    .digit_valid(m_dv), .seg_en(m_seg), .code_pushed(m_push), .fill_level(m_fill)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one byte for one cycle; returns at the following negedge, where
  // code_pushed for that byte is already visible.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    valid_code   = 1'b1;
    scan_code_in = b;
    @(negedge clk);
    valid_code   = 1'b0;
  endtask

  task automatic wait_seg(input logic [3:0] pat);
    bit seen = 0;
    @(negedge clk);
    for (int i = 0; i < 40 && !seen; i++) begin
      if (b_seg === pat) seen = 1;
      else @(negedge clk);
    end
    if (!seen) begin
      tests++;
      failed++;
      $error("FAIL wait_seg: seg_en never reached %b (observed %b)", pat, b_seg);
    end
  endtask

  task automatic check_digit(input int d, input logic dv, input logic ext,
                             input logic [7:0] code, input string tag);
    logic [3:0] pat;
    pat = ~(4'b0001 << d);
    wait_seg(pat);
    chk({tag, "_code"}, b_code, code);
    chk({tag, "_ext"},  b_ext,  ext);
    chk({tag, "_dv"},   b_dv,   dv);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_codes [4];
    logic [3:0] exp_segs  [4];
    exp_codes = '{8'h24, 8'h23, 8'h21, 8'h32};
    exp_segs  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    rst = 1'b1; valid_code = 1'b0; scan_code_in = 8'h00; clear = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_seg_en", b_seg,  4'b1110);
    chk("rst_code",   b_code, 8'h00);
    chk("rst_ext",    b_ext,  1'b0);
    chk("rst_dv",     b_dv,   1'b0);
    chk("rst_push",   b_push, 1'b0);
    chk("rst_fill",   b_fill, 3'd0);

    // Make then release of 1C
    send(8'h1C);
    chk("mk1c_push_b", b_push, 1'b0);
    chk("mk1c_push_m", m_push, 1'b1);
    send(8'hF0);
    chk("f0_push_b", b_push, 1'b0);
    chk("f0_push_m", m_push, 1'b0);
    send(8'h1C);
    chk("br1c_push_b", b_push, 1'b1);
    chk("br1c_push_m", m_push, 1'b0);
    chk("br1c_fill_b", b_fill, 3'd1);
    chk("br1c_fill_m", m_fill, 3'd1);
    check_digit(0, 1'b1, 1'b0, 8'h1C, "br1c_d0");
    chk("br1c_d0_code_m", m_code, 8'h1C);

    // Extended release E0 F0 75
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("ext75_push_b", b_push, 1'b1);
    chk("ext75_push_m", m_push, 1'b0);
    chk("ext75_fill_b", b_fill, 3'd2);
    check_digit(0, 1'b1, 1'b1, 8'h75, "ext75_d0");
    check_digit(1, 1'b1, 1'b0, 8'h1C, "ext75_d1");

    // Extended make E0 75: only the make-mode instance records it
    send(8'hE0);
    send(8'h75);
    chk("extmk_push_b", b_push, 1'b0);
    chk("extmk_push_m", m_push, 1'b1);
    chk("extmk_fill_b", b_fill, 3'd2);
    chk("extmk_fill_m", m_fill, 3'd2);
    check_digit(0, 1'b1, 1'b1, 8'h75, "extmk_d0");
    chk("extmk_d0_ext_m",  m_ext,  1'b1);
    chk("extmk_d0_code_m", m_code, 8'h75);

    // clear together with a make of 32: byte dropped, history flushed
    @(negedge clk);
    clear = 1'b1; valid_code = 1'b1; scan_code_in = 8'h32;
    @(negedge clk);
    clear = 1'b0; valid_code = 1'b0;
    chk("clr_push_m", m_push, 1'b0);
    chk("clr_push_b", b_push, 1'b0);
    chk("clr_fill_m", m_fill, 3'd0);
    chk("clr_fill_b", b_fill, 3'd0);
    check_digit(0, 1'b0, 1'b0, 8'h00, "clr_d0");
    chk("clr_d0_dv_m", m_dv, 1'b0);

    // Overflow: five releases, oldest (1C) lost
    send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h32);
    send(8'hF0); send(8'h21);
    send(8'hF0); send(8'h23);
    send(8'hF0); send(8'h24);
    chk("ovf_fill_b", b_fill, 3'd4);
    chk("ovf_fill_m", m_fill, 3'd0);
    for (int d = 0; d < 4; d++) check_digit(d, 1'b1, 1'b0, exp_codes[d], "ovf_d");

    // Scan: align on the 0111 -> 1110 transition, then 16 clocks
    wait_seg(4'b0111);
    wait_seg(4'b1110);
    for (int k = 0; k < 16; k++) begin
      chk("scan_seg",  b_seg,  exp_segs[k/4]);
      chk("scan_code", b_code, exp_codes[k/4]);
      @(negedge clk);
    end

    // Reset after a lone F0: following 1C is a fresh byte in IDLE
    send(8'hF0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_fill_b", b_fill, 3'd0);
    chk("mrst_seg_en", b_seg,  4'b1110);
    send(8'h1C);
    chk("mrst_push_b", b_push, 1'b0);
    chk("mrst_push_m", m_push, 1'b1);
    chk("mrst_fill_b2", b_fill, 3'd0);
    chk("mrst_fill_m", m_fill, 3'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
